// File: rtl/mem_access_unit.sv
// Initiator for the even/odd banked byte memory: splits byte-addressed 8/16-bit
// accesses and word bursts across both banks, and buffers read returns behind valid/ready.
module mem_access_unit #(
  parameter int BUFDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_byte,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd,
  output logic [14:0] write_addr_even,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_even,
  output logic [7:0]  write_data_odd,
  output logic        write_en_even,
  output logic        write_en_odd
);

  localparam int PW = (BUFDEPTH > 1) ? $clog2(BUFDEPTH) : 1;
  localparam int CW = $clog2(BUFDEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   addr_reg, addr_next;
  logic [7:0]    issue_left_reg, issue_left_next;
  logic [7:0]    words_left_reg, words_left_next;
  logic          byte_reg, byte_next;
  logic          done_reg, done_next;
  logic          inflight_reg;
  logic          steer_reg;

  logic [15:0]   fifo_mem [BUFDEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          cmd_fire, cmd_nop, accept_rd;
  logic [7:0]    cmd_words;
  logic          rd_pop, push, issue_burst, issue, wr_fire;
  logic [CW:0]   occ;
  logic [15:0]   issue_addr;
  logic [15:0]   ret_word;

  assign cmd_ready = (state_reg == IDLE);
  assign wr_ready  = (state_reg == WRITE);
  assign done      = done_reg;

  // Gated by reset_n so nothing is launched from cmd_* while reset is held.
  assign cmd_fire  = cmd_valid & cmd_ready & reset_n;
  assign cmd_words = cmd_byte ? 8'd1 : cmd_len;
  assign cmd_nop   = (cmd_words == 8'd0);
  assign accept_rd = cmd_fire & ~cmd_write & ~cmd_nop;

  assign rd_valid = (count_reg != '0);
  assign rd_data  = rd_valid ? fifo_mem[rd_ptr_reg] : 16'h0000;
  assign rd_pop   = rd_valid & rd_ready & (state_reg == READ);
  assign push     = inflight_reg;

  // A slot being popped this cycle is free for the word issued now.
  assign occ         = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(rd_pop);
  assign issue_burst = (state_reg == READ) && (issue_left_reg != 8'd0) &&
                       (occ < (CW+1)'(BUFDEPTH));
  assign issue       = accept_rd | issue_burst;

  // The first word issues in the accept cycle straight from cmd_addr.
  assign issue_addr     = accept_rd ? cmd_addr : addr_reg;
  assign read_addr_odd  = issue_addr[15:1];
  assign read_addr_even = issue_addr[15:1] + {14'b0, issue_addr[0]};

  assign wr_fire         = (state_reg == WRITE) & wr_valid;
  assign write_addr_odd  = addr_reg[15:1];
  assign write_addr_even = addr_reg[15:1] + {14'b0, addr_reg[0]};
  assign write_data_even = wr_fire ? (addr_reg[0] ? wr_data[15:8] : wr_data[7:0]) : 8'h00;
  assign write_data_odd  = wr_fire ? (addr_reg[0] ? wr_data[7:0] : wr_data[15:8]) : 8'h00;
  assign write_en_even   = wr_fire & (~byte_reg | ~addr_reg[0]);
  assign write_en_odd    = wr_fire & (~byte_reg | addr_reg[0]);

  // steer_reg remembers which bank held the low byte of the word now returning.
  always_comb begin
    ret_word = 16'h0000;
    if (byte_reg)
      ret_word = {8'h00, (steer_reg ? read_data_odd : read_data_even)};
    else if (steer_reg)
      ret_word = {read_data_even, read_data_odd};
    else
      ret_word = {read_data_odd, read_data_even};
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    issue_left_next = issue_left_reg;
    words_left_next = words_left_reg;
    byte_next       = byte_reg;
    done_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          byte_next = cmd_byte;
          if (cmd_nop) begin
            done_next = 1'b1;
          end else if (cmd_write) begin
            state_next      = WRITE;
            addr_next       = cmd_addr;
            words_left_next = cmd_words;
          end else begin
            state_next      = READ;
            addr_next       = cmd_addr + 16'd2;
            issue_left_next = cmd_words - 8'd1;
            words_left_next = cmd_words;
          end
        end
      end
      READ: begin
        if (issue_burst) begin
          addr_next       = addr_reg + 16'd2;
          issue_left_next = issue_left_reg - 8'd1;
        end
        if (rd_pop) begin
          words_left_next = words_left_reg - 8'd1;
          if (words_left_reg == 8'd1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (wr_fire) begin
          addr_next       = addr_reg + 16'd2;
          words_left_next = words_left_reg - 8'd1;
          if (words_left_reg == 8'd1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      addr_reg       <= 16'h0000;
      issue_left_reg <= 8'd0;
      words_left_reg <= 8'd0;
      byte_reg       <= 1'b0;
      done_reg       <= 1'b0;
      inflight_reg   <= 1'b0;
      steer_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      issue_left_reg <= issue_left_next;
      words_left_reg <= words_left_next;
      byte_reg       <= byte_next;
      done_reg       <= done_next;
      inflight_reg   <= issue;
      if (issue)
        steer_reg <= issue_addr[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PW'(BUFDEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (rd_pop)
        rd_ptr_reg <= (rd_ptr_reg == PW'(BUFDEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      if (push && !rd_pop)
        count_reg <= count_reg + 1'b1;
      else if (!push && rd_pop)
        count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= ret_word;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the even/odd banked byte memory. Each bank is 8 bits wide with 15-bit word addresses. Reads have 1-cycle registered latency; writes complete in one cycle.
- Accepts byte-addressed 8/16-bit read and write commands, with bursts of up to 255 little-endian 16-bit words.
- Splits every access across both banks in the same cycle, including unaligned accesses, and streams read data out with valid/ready backpressure.
- Sits between the CPU load/store/stack logic and the memory subsystem.

Parameters:
- BUFDEPTH, 2, read-return buffer entries (minimum 2; sustains 1 word/cycle)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_byte  in  1  1=single 8-bit access; cmd_len ignored
- cmd_addr  in  16  starting byte address
- cmd_len  in  8  number of 16-bit words; 0 = no-op
- wr_data  in  16  write word (byte access uses [7:0])
- wr_valid  in  1  write data offered
- wr_ready  out  1  write data consumed when wr_valid & wr_ready
- rd_data  out  16  read word (byte access: [15:8]=0)
- rd_valid  out  1  read data valid
- rd_ready  in  1  consumer accepts rd_data
- done  out  1  one-cycle completion pulse
- read_addr_even, read_addr_odd  out  15  bank read word addresses
- read_data_even, read_data_odd  in  8  bank read data, valid the cycle after the address
- write_addr_even, write_addr_odd  out  15  bank write word addresses
- write_data_even, write_data_odd  out  8  bank write data
- write_en_even, write_en_odd  out  1  bank write strobes

Behaviour:
- Address split for byte address A (little-endian; low byte at A, high byte at A+1):
  - A[0]=0: low byte in even bank at A[15:1]; high byte in odd bank at A[15:1].
  - A[0]=1: low byte in odd bank at A[15:1]; high byte in even bank at A[15:1]+1, wrapping mod 2^15.
- Byte address advances by 2 per word and wraps 16'hFFFF->16'h0000. The word at 16'hFFFF uses odd bank 15'h7FFF (low) and even bank 15'h0000 (high).
- Byte access touches only the bank selected by A[0].
- State machine: IDLE, READ, WRITE.
  - cmd_ready = (state==IDLE), including while reset_n is low.
  - Accept with len>0 (or cmd_byte) -> READ or WRITE.
  - Accept with len=0 -> stay IDLE, done pulses next cycle, no bank activity.
- READ:
  - Issue one word's addresses per cycle while issued-but-unreturned words plus buffered words < BUFDEPTH and words remain.
  - The A[0] steering bit of each issue is registered so the returning bytes are swapped correctly one cycle later.
  - Returned data enters a FIFO of BUFDEPTH entries. rd_valid = FIFO non-empty; rd_data = FIFO head.
  - Never issue beyond cmd_len. Never drop or duplicate a word under any rd_ready pattern. With rd_ready held high, words arrive back-to-back, first rd_valid 2 cycles after acceptance.
  - After the last rd handshake -> IDLE; done=1 in the following cycle, and cmd_ready=1 in that same cycle.
- WRITE:
  - wr_ready=1 in WRITE. Each wr handshake drives both banks' addresses, data and write_en in that same cycle (combinational from wr_data/wr_valid), then advances the address.
  - Byte write asserts only the selected bank's write_en.
  - write_en_* = 0 whenever no wr handshake occurs.
  - After the last word -> IDLE; done pulses next cycle.
- Simultaneous events:
  - A new command cannot be accepted in the cycle done is asserted unless state is IDLE; it is IDLE, so back-to-back commands are allowed.
  - wr_valid/rd_ready are ignored outside their state.
- Reset (asynchronous, any time, including mid-burst):
  - State=IDLE; FIFO and in-flight reads are flushed, and late bank data is discarded.
  - rd_valid=0, done=0, wr_ready=0, write_en_*=0, all address/data outputs=0.
- Read addresses when not issuing: don't-care, but never spuriously counted as issues.

Test Plan:
- Aligned read, addr 16'h0100, len 1, memory bytes [0x0100]=0x34, [0x0101]=0x12 -> both banks at 15'h0080; rd_data=16'h1234 two cycles after accept; done next cycle after handshake.
- Unaligned read, addr 16'h0101, len 2, bytes 0x0101..0x0104 = 11 22 33 44 -> words 16'h2211 then 16'h4433. Even-bank addresses 15'h0081/15'h0082; odd 15'h0080/15'h0081.
- Burst read, len 8, rd_ready pseudo-random (toggling 1 0 0 1 ...) -> exactly 8 words in address order, no gaps, no repeats. Never more than BUFDEPTH buffered; with rd_ready=1 throughput is 1 word/cycle.
- Write wrap, addr 16'hFFFF, len 1, wr_data 16'hBEEF -> write_en_odd at 15'h7FFF data 8'hEF and write_en_even at 15'h0000 data 8'hBE, same cycle. Byte write addr 16'h0010 data 16'h00AA -> only write_en_even, addr 15'h0008, data 8'hAA.
- len=0 read, then immediate len=1 read -> done one cycle after first accept, zero bank reads; second command accepted in the done cycle and completes normally.
- Assert reset_n=0 mid-burst (after 3 of 8 words issued, rd_ready=0), release -> rd_valid=0 and no write_en. cmd_ready=1; a fresh len 1 read returns correct data with no stale words.
